wide_adder_seq: RTL and testbench

Sequential wide-operand adder that time-multiplexes one SEG-bit ripple-carry adder stage across a WIDTH-bit addition. It processes one segment per clock, least significant first, and registers the carry between segments. It sits directly upstream of the SEG-bit adder: it drives the adder's a/b/cin, captures its s/cout, and presents the full WIDTH-bit result to the consumer through a valid/ready handshake.

---
 rtl/wide_adder_seq.sv | 102 ++++++++++
 tb/tb_wide_adder_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/wide_adder_seq.sv
// wide_adder_seq: WIDTH-bit adder built by stepping one SEG-bit ripple-carry stage across the operand, LSB segment first.
module rca_seg #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout
);
  logic [SEG:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < SEG; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[SEG];
endmodule

module wide_adder_seq #(
  parameter int WIDTH = 128,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NSEG = WIDTH / SEG;
  localparam int KW = NSEG > 1 ? $clog2(NSEG) : 1;
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NSEG - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [KW-1:0] k;
  logic [IW-1:0] base;
  logic carry, co;
  logic [SEG-1:0] s;
  logic [WIDTH-1:0] a_r, b_r, work, work_nxt;
  assign base = IW'(k * SEG);
  rca_seg #(.SEG(SEG)) u_rca (
    .a(a_r[base +: SEG]),
    .b(b_r[base +: SEG]),
    .cin(carry),
    .s(s),
    .cout(co)
  );
  // The final segment is folded in here so sum is complete on the RUN->DONE edge.
  always_comb begin
    work_nxt = work;
    work_nxt[base +: SEG] = s;
  end
  assign in_ready = state == IDLE;
  assign busy = !in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      carry <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      work <= '0;
      sum <= '0;
      cout <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= op_a;
          b_r <= op_b;
          carry <= cin;
          k <= '0;
          state <= RUN;
        end
        RUN: begin
          work <= work_nxt;
          carry <= co;
          k <= k + 1'b1;
          if (k == KLAST) begin
            sum <= work_nxt;
            cout <= co;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wide_adder_seq.sv
// tb_wide_adder_seq: table vectors, corner sequences and random regression for wide_adder_seq.
module tb_wide_adder_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, cin = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, cout, busy;
  logic [127:0] op_a = '0, op_b = '0, sum;
  logic iv1 = 1'b0, ci1 = 1'b0, or1 = 1'b1;
  logic ir1, ov1, co1, bz1;
  logic [15:0] a1 = '0, b1 = '0, s1;
  int checks = 0, failures = 0;

  wide_adder_seq #(.WIDTH(128), .SEG(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );
  wide_adder_seq #(.WIDTH(16), .SEG(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .op_a(a1), .op_b(b1), .cin(ci1), .out_valid(ov1),
    .out_ready(or1), .sum(s1), .cout(co1), .busy(bz1)
  );

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where out_valid is seen.
  task automatic do_op(input logic [127:0] a, input logic [127:0] b, input logic c, output int lat);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    cin = c;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic         c;
    logic [127:0] s;
    logic         co;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int lat;
    logic [127:0] ra, rb;
    logic rc;
    logic [128:0] exp;
    tbl[0] = '{128'd5, 128'd7, 1'b0, 128'd12, 1'b0};
    tbl[1] = '{{128{1'b1}}, 128'd0, 1'b1, 128'd0, 1'b1};
    tbl[2] = '{{16'h7FFF, {112{1'b1}}}, 128'd1, 1'b0, {1'b1, 127'd0}, 1'b0};
    tbl[3] = '{{1'b1, 127'd0}, {1'b1, 127'd0}, 1'b0, 128'd0, 1'b1};
    tbl[4] = '{{128{1'b1}}, {128{1'b1}}, 1'b1, {128{1'b1}}, 1'b1};
    tbl[5] = '{128'h0000_FFFF_0000_FFFF_0000_FFFF_0000_FFFF, 128'h0000_0001_0000_0001_0000_0001_0000_0001, 1'b1,
               128'h0001_0000_0001_0000_0001_0000_0001_0001, 1'b0};
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sum", {cout, sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("tbl%0d_in_ready", i), in_ready, 1);
      do_op(tbl[i].a, tbl[i].b, tbl[i].c, lat);
      chk($sformatf("tbl%0d_latency", i), lat, 8);
      chk($sformatf("tbl%0d_busy", i), busy, 1);
      chk($sformatf("tbl%0d_sum", i), sum, tbl[i].s);
      chk($sformatf("tbl%0d_cout", i), cout, tbl[i].co);
      @(negedge clk);
      chk($sformatf("tbl%0d_handshake", i), {out_valid, in_ready}, 2'b01);
    end
    // Backpressure with ignored in_valid pulses during RUN and DONE.
    out_ready = 1'b0;
    in_valid = 1'b1;
    op_a = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    op_b = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    cin = 1'b1;
    @(negedge clk);
    op_a = {128{1'b1}};
    op_b = 128'd99;
    cin = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      op_a = {$urandom, $urandom, $urandom, $urandom};
    end
    chk("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), {out_valid, cout, sum},
          {1'b1, 129'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321 + 129'h1111_2222_3333_4444_5555_6666_7777_8888 + 129'd1});
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {out_valid, in_ready}, 2'b01);
    // Asynchronous reset mid-RUN.
    do_op(128'd3, 128'd4, 1'b0, lat);
    @(negedge clk);
    in_valid = 1'b1;
    op_a = 128'hFFFF;
    op_b = 128'h1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", {out_valid, busy, cout, sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", {in_ready, busy}, 2'b10);
    do_op(128'd1, 128'd1, 1'b0, lat);
    chk("arst_fresh_lat", lat, 8);
    chk("arst_fresh_sum", {cout, sum}, 129'd2);
    @(negedge clk);
    // NSEG=1 instance.
    iv1 = 1'b1;
    a1 = 16'h8000;
    b1 = 16'h8000;
    @(negedge clk);
    iv1 = 1'b0;
    chk("n1_run", {ov1, bz1}, 2'b01);
    @(negedge clk);
    chk("n1_done", {ov1, co1, s1}, {1'b1, 1'b1, 16'h0});
    @(negedge clk);
    chk("n1_idle", {ov1, ir1}, 2'b01);
    // Random back-to-back regression.
    for (int n = 0; n < 1000; n++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = (n % 4 == 0) ? ~ra : {$urandom, $urandom, $urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      exp = {1'b0, ra} + {1'b0, rb} + {128'd0, rc};
      out_ready = 1'b0;
      do_op(ra, rb, rc, lat);
      chk("rand_latency", lat, 8);
      chk("rand_result", {cout, sum}, exp);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("rand_hold", {out_valid, cout, sum}, {1'b1, exp});
      out_ready = 1'b1;
      @(negedge clk);
      chk("rand_handshake", out_valid, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
